// File: rtl/serial_add_ctrl_if.sv
// ============================================================================
// serial_add_ctrl_if : start/busy/done handshake and operand/result bus
// Rev 1.0
// ============================================================================
`default_nettype none

interface serial_add_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output start, sub, a, b, cin,
    input  busy, done, sum, cout, ovf
  );

  modport slave (
    input  start, sub, a, b, cin,
    output busy, done, sum, cout, ovf
  );
endinterface

`default_nettype wire

// File: rtl/serial_add_ctrl.sv
// ============================================================================
// serial_add_ctrl : bit-serial add/subtract over one shared full-adder cell
// Rev 1.0
// ============================================================================
`default_nettype none

module fulladd (
  input  wire  cin,
  input  wire  x,
  input  wire  y,
  output logic f,
  output logic cout
);
  always_comb begin
    f    = x ^ y ^ cin;
    cout = (x & y) | (cin & (x ^ y));
  end
endmodule

module serial_add_ctrl #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 5
) (
  input  wire                 clk,
  input  wire                 rst,
  serial_add_ctrl_if.slave    bus
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [CNT_W-1:0] C_LAST_BIT = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] C_CNT_ONE  = CNT_W'(1);

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_sh_q,  a_sh_d;
  logic [WIDTH-1:0] b_sh_q,  b_sh_d;
  logic [WIDTH-1:0] r_sh_q,  r_sh_d;
  logic             carry_q, carry_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic             busy_q,  busy_d;
  logic             done_q,  done_d;
  logic [WIDTH-1:0] sum_q,   sum_d;
  logic             cout_q,  cout_d;
  logic             ovf_q,   ovf_d;

  logic w_f;
  logic w_co;

  fulladd u_fulladd (
    .cin  (carry_q),
    .x    (a_sh_q[0]),
    .y    (b_sh_q[0]),
    .f    (w_f),
    .cout (w_co)
  );

  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    r_sh_d  = r_sh_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          // Subtract is a + ~b + 1, so the inverted operand and a forced carry-in do the job.
          a_sh_d  = bus.a;
          b_sh_d  = bus.sub ? ~bus.b : bus.b;
          carry_d = bus.sub ? 1'b1 : bus.cin;
          cnt_d   = '0;
          r_sh_d  = '0;
          busy_d  = 1'b1;
          state_d = ST_RUN;
        end
      end

      ST_RUN: begin
        r_sh_d  = {w_f, r_sh_q[WIDTH-1:1]};
        a_sh_d  = a_sh_q >> 1;
        b_sh_d  = b_sh_q >> 1;
        carry_d = w_co;
        cnt_d   = cnt_q + C_CNT_ONE;
        if (cnt_q == C_LAST_BIT) begin
          // carry_q here is the carry into the MSB; differing from carry out means overflow.
          sum_d   = {w_f, r_sh_q[WIDTH-1:1]};
          cout_d  = w_co;
          ovf_d   = carry_q ^ w_co;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = ST_DONE;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      r_sh_q  <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      r_sh_q  <= r_sh_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;
  assign bus.ovf  = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_serial_add_ctrl.sv
// ============================================================================
// tb_serial_add_ctrl : directed vectors and handshake sequences for serial_add_ctrl
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_serial_add_ctrl;

  localparam int WIDTH = 8;

  typedef struct {
    logic             sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
  } vec_t;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_bad;

  serial_add_ctrl_if #(.WIDTH(WIDTH)) sa_if ();

  serial_add_ctrl #(.WIDTH(WIDTH), .CNT_W(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (sa_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Issue one operation and return the number of edges after E0 until done is seen.
  task automatic run_op(input logic s, input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                        input logic ci, output int lat);
    @(negedge clk);
    sa_if.start = 1'b1;
    sa_if.sub   = s;
    sa_if.a     = av;
    sa_if.b     = bv;
    sa_if.cin   = ci;
    @(posedge clk);
    @(negedge clk);
    sa_if.start = 1'b0;
    sa_if.a     = WIDTH'($urandom);
    sa_if.b     = WIDTH'($urandom);
    sa_if.cin   = ~ci;
    sa_if.sub   = ~s;
    chk("busy_after_start", 32'(sa_if.busy), 32'd1);
    lat = 0;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (sa_if.done) begin
        lat = n;
        break;
      end
    end
  endtask

  vec_t vecs [11];
  int   lat;
  int   dcnt;
  int   dpos [3];

  initial begin
    vecs[0]  = '{1'b0, 8'h3C, 8'h5A, 1'b0, 8'h96, 1'b0, 1'b1};
    vecs[1]  = '{1'b0, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
    vecs[2]  = '{1'b0, 8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0};
    vecs[3]  = '{1'b1, 8'h05, 8'h07, 1'b0, 8'hFE, 1'b0, 1'b0};
    vecs[4]  = '{1'b1, 8'h80, 8'h01, 1'b0, 8'h7F, 1'b1, 1'b1};
    vecs[5]  = '{1'b0, 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
    vecs[6]  = '{1'b1, 8'h00, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0};
    vecs[7]  = '{1'b0, 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
    vecs[8]  = '{1'b1, 8'h7F, 8'hFF, 1'b0, 8'h80, 1'b0, 1'b1};
    vecs[9]  = '{1'b1, 8'h10, 8'h03, 1'b1, 8'h0D, 1'b1, 1'b0};
    vecs[10] = '{1'b0, 8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};

    n_cmp = 0;
    n_bad = 0;
    rst = 1'b1;
    sa_if.start = 1'b0;
    sa_if.sub   = 1'b0;
    sa_if.a     = '0;
    sa_if.b     = '0;
    sa_if.cin   = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_busy", 32'(sa_if.busy), 32'd0);
    chk("rst_done", 32'(sa_if.done), 32'd0);
    chk("rst_sum",  32'(sa_if.sum),  32'd0);
    chk("rst_cout", 32'(sa_if.cout), 32'd0);
    chk("rst_ovf",  32'(sa_if.ovf),  32'd0);

    foreach (vecs[i]) begin
      run_op(vecs[i].sub, vecs[i].a, vecs[i].b, vecs[i].cin, lat);
      chk($sformatf("vec%0d_latency", i), 32'(lat), 32'(WIDTH));
      chk($sformatf("vec%0d_sum", i),  32'(sa_if.sum),  32'(vecs[i].sum));
      chk($sformatf("vec%0d_cout", i), 32'(sa_if.cout), 32'(vecs[i].cout));
      chk($sformatf("vec%0d_ovf", i),  32'(sa_if.ovf),  32'(vecs[i].ovf));
      chk($sformatf("vec%0d_busy_at_done", i), 32'(sa_if.busy), 32'd0);
    end
    @(negedge clk);
    chk("done_one_cycle", 32'(sa_if.done), 32'd0);

    // Result hold: previous sum must persist until the new completion edge.
    run_op(1'b0, 8'h3C, 8'h5A, 1'b0, lat);
    chk("hold_first_sum", 32'(sa_if.sum), 32'h96);
    @(negedge clk);
    sa_if.start = 1'b1; sa_if.sub = 1'b0; sa_if.a = 8'h01; sa_if.b = 8'h01; sa_if.cin = 1'b0;
    @(posedge clk);
    @(negedge clk);
    sa_if.start = 1'b0;
    for (int n = 1; n <= WIDTH - 1; n++) begin
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("hold_sum_e%0d", n), 32'(sa_if.sum), 32'h96);
    end
    @(posedge clk);
    @(negedge clk);
    chk("hold_done_e8", 32'(sa_if.done), 32'd1);
    chk("hold_new_sum", 32'(sa_if.sum), 32'h02);

    // Second start during RUN is ignored and nothing is queued.
    @(negedge clk);
    sa_if.start = 1'b1; sa_if.sub = 1'b0; sa_if.a = 8'h10; sa_if.b = 8'h20; sa_if.cin = 1'b0;
    @(posedge clk);
    @(negedge clk);
    sa_if.start = 1'b0;
    lat = 0;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (n == 2) begin
        sa_if.start = 1'b1; sa_if.a = 8'hFF; sa_if.b = 8'hFF;
      end else begin
        sa_if.start = 1'b0;
      end
      if (sa_if.done) begin
        lat = n;
        break;
      end
    end
    chk("ign_latency", 32'(lat), 32'(WIDTH));
    chk("ign_sum", 32'(sa_if.sum), 32'h30);
    dcnt = 0;
    for (int n = 0; n < 14; n++) begin
      @(negedge clk);
      if (sa_if.done || sa_if.busy) dcnt++;
    end
    chk("ign_no_queue", 32'(dcnt), 32'd0);

    // start held high: operations begin every WIDTH+2 edges.
    @(negedge clk);
    sa_if.start = 1'b1; sa_if.sub = 1'b0; sa_if.a = 8'h01; sa_if.b = 8'h01; sa_if.cin = 1'b0;
    dcnt = 0;
    for (int k = 0; k < 30; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (sa_if.done) begin
        if (dcnt < 3) dpos[dcnt] = k;
        dcnt++;
      end
    end
    sa_if.start = 1'b0;
    chk("cont_done_count", 32'(dcnt), 32'd3);
    chk("cont_done0", 32'(dpos[0]), 32'd8);
    chk("cont_done1", 32'(dpos[1]), 32'd18);
    chk("cont_done2", 32'(dpos[2]), 32'd28);
    chk("cont_sum", 32'(sa_if.sum), 32'h02);
    repeat (3) @(negedge clk);
    chk("cont_idle", 32'(sa_if.busy), 32'd0);

    // Reset in the middle of an operation.
    @(negedge clk);
    sa_if.start = 1'b1; sa_if.sub = 1'b0; sa_if.a = 8'h11; sa_if.b = 8'h22; sa_if.cin = 1'b0;
    @(posedge clk);
    @(negedge clk);
    sa_if.start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_busy", 32'(sa_if.busy), 32'd0);
    chk("midrst_sum",  32'(sa_if.sum),  32'd0);
    chk("midrst_cout", 32'(sa_if.cout), 32'd0);
    chk("midrst_ovf",  32'(sa_if.ovf),  32'd0);
    dcnt = 0;
    for (int n = 0; n < 12; n++) begin
      @(negedge clk);
      if (sa_if.done) dcnt++;
    end
    chk("midrst_no_done", 32'(dcnt), 32'd0);

    // Recovery after reset.
    run_op(1'b0, 8'h01, 8'h02, 1'b0, lat);
    chk("recov_latency", 32'(lat), 32'(WIDTH));
    chk("recov_sum", 32'(sa_if.sum), 32'h03);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
